timer_counter: RTL

Memory-mapped 32-bit down-counting timer, instantiated twice (TC0, TC1) as a peripheral behind the CPU's system bridge. The bridge decodes the timer's address window and drives this block's write strobe, address and write data. The block returns the read data word and the interrupt request that the bridge folds into the CPU's hardware-interrupt vector. It supports one-shot (mode 0) and auto-reload (mode 1) operation through a 4-state FSM.

---
 rtl/timer_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;

  logic [31:0] w_count_nxt;
  logic        w_irq_nxt;
  logic        w_en_clr;
  logic        w_enable;
  logic        w_one_shot;
  logic        w_unused;

  assign w_enable   = r_ctrl[0];
  assign w_one_shot = (r_ctrl[2:1] == 2'b00);
  assign w_unused   = &{1'b0, Addr[31:4]};

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_irq_nxt   = r_irq;
    w_en_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_enable) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!w_enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // PRESET of 0 lands here too, so it behaves exactly like PRESET of 1
          w_count_nxt = 32'd0;
          w_irq_nxt   = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        w_state_nxt = S_IDLE;
        if (w_one_shot) begin
          w_en_clr = 1'b1;
        end else begin
          w_irq_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A bus write owns the cycle: the FSM and COUNT are frozen while WE is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'h0;
      r_preset <= 32'h0;
      r_count  <= 32'h0;
      r_irq    <= 1'b0;
    end else if (WE) begin
      case (Addr[3:2])
        2'd0:    r_ctrl   <= Din[3:0];
        2'd1:    r_preset <= Din;
        default: ;
      endcase
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_irq   <= w_irq_nxt;
      if (w_en_clr) begin
        r_ctrl[0] <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = 32'h0;
    case (Addr[3:2])
      2'd0:    Dout = {28'h0, r_ctrl};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'h0;
    endcase
  end

  assign IRQ = r_irq & r_ctrl[3];

endmodule
